fflags_accum_ram: RTL and testbench



---
 rtl/fflags_accum_ram_pkg.sv | 23 ++
 rtl/fflags_accum_ram_if.sv | 28 ++
 rtl/fflags_accum_ram_wport_merge.sv | 54 +++++
 rtl/fflags_accum_ram.sv | 136 +++++++++++++
 tb/tb_fflags_accum_ram.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fflags_accum_ram_pkg.sv
// Shared constants, write-mode encoding and address helper for the fflags array.
package fflags_ram_pkg;

    localparam int DEPTH_DEF = 5;
    localparam int WIDTH_DEF = 5;

    typedef enum logic {
        WR_OVERWRITE = 1'b0,
        WR_ACCUM     = 1'b1
    } wr_mode_e;

    // True when a zero-extended address selects an existing entry.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        logic ok_s;
        if (addr < depth) begin
            ok_s = 1'b1;
        end else begin
            ok_s = 1'b0;
        end
        return ok_s;
    endfunction

endpackage

// File: rtl/fflags_accum_ram_if.sv
// Write/clear/read bundle between the FP pipes, commit and the flag array.
interface fflags_accum_ram_if #(
    parameter int NUM_WPORTS = 2,
    parameter int ADDR_W     = 3,
    parameter int WIDTH      = 5
);
    logic [NUM_WPORTS-1:0]        w_en;
    logic [NUM_WPORTS*ADDR_W-1:0] w_addr;
    logic [NUM_WPORTS-1:0]        w_acc;
    logic [NUM_WPORTS*WIDTH-1:0]  w_data;
    logic                         clr_en;
    logic [ADDR_W-1:0]            clr_addr;
    logic                         r_en;
    logic [ADDR_W-1:0]            r_addr;
    logic [WIDTH-1:0]             r_data;
    logic                         r_valid;
    logic [WIDTH-1:0]             acc_flags;

    modport master (
        output w_en, w_addr, w_acc, w_data, clr_en, clr_addr, r_en, r_addr,
        input  r_data, r_valid, acc_flags
    );

    modport slave (
        input  w_en, w_addr, w_acc, w_data, clr_en, clr_addr, r_en, r_addr,
        output r_data, r_valid, acc_flags
    );
endinterface

// File: rtl/fflags_accum_ram_wport_merge.sv
// Per-entry next-state resolver: highest-index overwrite wins, accumulates OR on top.
module fflags_wport_merge
    import fflags_ram_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter int NUM_WPORTS = 2
) (
    input  logic [NUM_WPORTS-1:0]       hit,
    input  logic [NUM_WPORTS-1:0]       acc,
    input  logic [NUM_WPORTS*WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0]            cur_data,
    input  logic                        cur_valid,
    input  logic                        clr_hit,
    output logic [WIDTH-1:0]            next_data,
    output logic                        next_valid
);

    // Base value: stale/cleared content starts from zero, overwrites replace it; then OR in accumulates.
    always_comb begin
        next_data = {WIDTH{1'b0}};
        if (clr_hit || !cur_valid) begin
            next_data = {WIDTH{1'b0}};
        end else begin
            next_data = cur_data;
        end
        for (int p = 0; p < NUM_WPORTS; p++) begin
            if (hit[p] && (wr_mode_e'(acc[p]) == WR_OVERWRITE)) begin
                next_data = wdata[p*WIDTH +: WIDTH];
            end else begin
                next_data = next_data;
            end
        end
        for (int p = 0; p < NUM_WPORTS; p++) begin
            if (hit[p] && (wr_mode_e'(acc[p]) == WR_ACCUM)) begin
                next_data = next_data | wdata[p*WIDTH +: WIDTH];
            end else begin
                next_data = next_data;
            end
        end
    end

    // Any write validates the entry and beats a same-cycle clear.
    always_comb begin
        next_valid = 1'b0;
        if (|hit) begin
            next_valid = 1'b1;
        end else if (clr_hit) begin
            next_valid = 1'b0;
        end else begin
            next_valid = cur_valid;
        end
    end

endmodule

// File: rtl/fflags_accum_ram.sv
// Sticky FP exception flag array per ROB slot: multi-port write/accumulate, one read, OR summary.
module fflags_accum_ram
    import fflags_ram_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int NUM_WPORTS = 2,
    parameter int REG_READ   = 1
) (
    input  logic              clock,
    input  logic              reset,
    fflags_accum_ram_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]      data_r      [DEPTH];
    logic [DEPTH-1:0]      valid_r;
    logic [WIDTH-1:0]      next_data_s [DEPTH];
    logic [DEPTH-1:0]      next_valid_s;
    logic [WIDTH-1:0]      rd_data_s;
    logic                  rd_valid_s;
    logic [WIDTH-1:0]      acc_s;
    logic [WIDTH-1:0]      acc_r;

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        localparam logic [ADDR_W-1:0] E_ADDR = ADDR_W'(e);
        logic [NUM_WPORTS-1:0] hit_s;
        logic                  clr_hit_s;

        // Decode which ports and whether the clear target this entry; out-of-range never matches.
        always_comb begin
            hit_s = {NUM_WPORTS{1'b0}};
            for (int p = 0; p < NUM_WPORTS; p++) begin
                if (bus.w_en[p] && (bus.w_addr[p*ADDR_W +: ADDR_W] == E_ADDR)
                    && addr_in_range(32'(bus.w_addr[p*ADDR_W +: ADDR_W]), DEPTH)) begin
                    hit_s[p] = 1'b1;
                end else begin
                    hit_s[p] = 1'b0;
                end
            end
            if (bus.clr_en && (bus.clr_addr == E_ADDR) && addr_in_range(32'(bus.clr_addr), DEPTH)) begin
                clr_hit_s = 1'b1;
            end else begin
                clr_hit_s = 1'b0;
            end
        end

        fflags_wport_merge #(
            .WIDTH      (WIDTH),
            .NUM_WPORTS (NUM_WPORTS)
        ) u_merge (
            .hit        (hit_s),
            .acc        (bus.w_acc),
            .wdata      (bus.w_data),
            .cur_data   (data_r[e]),
            .cur_valid  (valid_r[e]),
            .clr_hit    (clr_hit_s),
            .next_data  (next_data_s[e]),
            .next_valid (next_valid_s[e])
        );

        // Data storage is not reset; invalid entries are always masked on every output.
        always_ff @(posedge clock) begin
            data_r[e] <= next_data_s[e];
        end
    end

    // Valid bits: reset overrides every same-cycle write and clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r <= {DEPTH{1'b0}};
        end else begin
            valid_r <= next_valid_s;
        end
    end

    // Read-first lookup from current state, masked by valid, idle and range.
    always_comb begin
        rd_data_s  = {WIDTH{1'b0}};
        rd_valid_s = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            if (bus.r_en && (bus.r_addr == ADDR_W'(e))) begin
                rd_valid_s = valid_r[e];
                rd_data_s  = valid_r[e] ? data_r[e] : {WIDTH{1'b0}};
            end else begin
                rd_valid_s = rd_valid_s;
            end
        end
    end

    if (REG_READ != 0) begin : g_reg_read
        logic [WIDTH-1:0] r_data_r;
        logic             r_valid_r;

        // Registered read port, one cycle after r_en.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_data_r  <= {WIDTH{1'b0}};
                r_valid_r <= 1'b0;
            end else begin
                r_data_r  <= rd_data_s;
                r_valid_r <= rd_valid_s;
            end
        end
        assign bus.r_data  = r_data_r;
        assign bus.r_valid = r_valid_r;
    end else begin : g_comb_read
        assign bus.r_data  = rd_data_s;
        assign bus.r_valid = rd_valid_s;
    end

    // OR of all valid entries from current state.
    always_comb begin
        acc_s = {WIDTH{1'b0}};
        for (int e = 0; e < DEPTH; e++) begin
            if (valid_r[e]) begin
                acc_s = acc_s | data_r[e];
            end else begin
                acc_s = acc_s;
            end
        end
    end

    // Summary register, one cycle behind the array state.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_r <= {WIDTH{1'b0}};
        end else begin
            acc_r <= acc_s;
        end
    end

    assign bus.acc_flags = acc_r;

endmodule

// File: tb/tb_fflags_accum_ram.sv
// Scenario bench for fflags_accum_ram (DEPTH=5, WIDTH=5, two write ports, registered read).
module tb_fflags_accum_ram;

    localparam int DEPTH  = 5;
    localparam int WIDTH  = 5;
    localparam int NWP    = 2;
    localparam int ADDR_W = 3;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    // Expected read results {r_data, r_valid}, pushed on r_en and popped after the read edge.
    logic [WIDTH:0] exp_q [$];
    logic [WIDTH:0] exp_v;

    fflags_accum_ram_if #(.NUM_WPORTS(NWP), .ADDR_W(ADDR_W), .WIDTH(WIDTH)) bus ();

    fflags_accum_ram #(
        .DEPTH      (DEPTH),
        .WIDTH      (WIDTH),
        .NUM_WPORTS (NWP),
        .REG_READ   (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout r_data=%b required completion", bus.r_data);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.w_en     = '0;
        bus.w_addr   = '0;
        bus.w_acc    = '0;
        bus.w_data   = '0;
        bus.clr_en   = 1'b0;
        bus.clr_addr = '0;
        bus.r_en     = 1'b0;
        bus.r_addr   = '0;
    endtask

    task automatic set_wr(input int p, input logic [ADDR_W-1:0] a, input logic acc, input logic [WIDTH-1:0] d);
        bus.w_en[p]                    = 1'b1;
        bus.w_addr[p*ADDR_W +: ADDR_W] = a;
        bus.w_acc[p]                   = acc;
        bus.w_data[p*WIDTH +: WIDTH]   = d;
    endtask

    task automatic set_rd(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d, input logic v);
        bus.r_en   = 1'b1;
        bus.r_addr = a;
        exp_q.push_back({d, v});
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (bus.r_data !== 5'b00000 || bus.r_valid !== 1'b0 || bus.acc_flags !== 5'b00000) begin
            n_errors++;
            $display("FAIL reset_out got %b/%b/%b want 00000/0/00000", bus.r_data, bus.r_valid, bus.acc_flags);
        end
        for (int a = 0; a < DEPTH; a++) begin
            idle();
            set_rd(ADDR_W'(a), 5'b00000, 1'b0);
            tick();
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({bus.r_data, bus.r_valid} !== exp_v || bus.acc_flags !== 5'b00000) begin
                n_errors++;
                $display("FAIL reset_read%0d got %b/%b acc %b want %b acc 00000", a, bus.r_data, bus.r_valid, bus.acc_flags, exp_v);
            end
        end
    endtask

    task automatic test_accum();
        idle();
        set_wr(0, 3'd2, 1'b0, 5'b00101);
        tick();
        idle();
        set_wr(1, 3'd2, 1'b1, 5'b10000);
        tick();
        idle();
        n_checks++;
        if (bus.r_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL accum_pre_read got r_valid %b want 0", bus.r_valid);
        end
        set_rd(3'd2, 5'b10101, 1'b1);
        tick();
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({bus.r_data, bus.r_valid} !== exp_v) begin
            n_errors++;
            $display("FAIL accum_read got %b/%b want %b", bus.r_data, bus.r_valid, exp_v);
        end
        idle();
        tick();
        n_checks++;
        if (bus.r_data !== 5'b00000 || bus.r_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL read_idle got %b/%b want 00000/0", bus.r_data, bus.r_valid);
        end
    endtask

    task automatic test_same_cycle();
        idle();
        set_wr(0, 3'd3, 1'b0, 5'b00001);
        set_wr(1, 3'd3, 1'b0, 5'b00100);
        tick();
        idle();
        set_rd(3'd3, 5'b00100, 1'b1);
        tick();
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({bus.r_data, bus.r_valid} !== exp_v) begin
            n_errors++;
            $display("FAIL both_overwrite got %b/%b want %b", bus.r_data, bus.r_valid, exp_v);
        end
        idle();
        set_wr(0, 3'd3, 1'b0, 5'b00001);
        set_wr(1, 3'd3, 1'b1, 5'b00100);
        tick();
        idle();
        set_rd(3'd3, 5'b00101, 1'b1);
        tick();
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({bus.r_data, bus.r_valid} !== exp_v) begin
            n_errors++;
            $display("FAIL ow_plus_acc got %b/%b want %b", bus.r_data, bus.r_valid, exp_v);
        end
    endtask

    task automatic test_clear();
        idle();
        set_wr(0, 3'd1, 1'b0, 5'b11111);
        tick();
        idle();
        bus.clr_en   = 1'b1;
        bus.clr_addr = 3'd1;
        set_wr(0, 3'd1, 1'b1, 5'b00010);
        tick();
        idle();
        bus.clr_en   = 1'b1;
        bus.clr_addr = 3'd1;
        set_rd(3'd1, 5'b00010, 1'b1);
        tick();
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({bus.r_data, bus.r_valid} !== exp_v) begin
            n_errors++;
            $display("FAIL clr_plus_acc got %b/%b want %b", bus.r_data, bus.r_valid, exp_v);
        end
        idle();
        set_rd(3'd1, 5'b00000, 1'b0);
        tick();
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({bus.r_data, bus.r_valid} !== exp_v) begin
            n_errors++;
            $display("FAIL clr_alone got %b/%b want %b", bus.r_data, bus.r_valid, exp_v);
        end
    endtask

    task automatic test_read_first();
        idle();
        set_wr(0, 3'd4, 1'b0, 5'b01000);
        set_rd(3'd4, 5'b00000, 1'b0);
        tick();
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({bus.r_data, bus.r_valid} !== exp_v) begin
            n_errors++;
            $display("FAIL read_first got %b/%b want %b", bus.r_data, bus.r_valid, exp_v);
        end
        idle();
        set_rd(3'd4, 5'b01000, 1'b1);
        tick();
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({bus.r_data, bus.r_valid} !== exp_v) begin
            n_errors++;
            $display("FAIL read_after got %b/%b want %b", bus.r_data, bus.r_valid, exp_v);
        end
    endtask

    task automatic test_acc_flags();
        test_reset();
        idle();
        set_wr(0, 3'd0, 1'b0, 5'b00001);
        tick();
        idle();
        set_wr(1, 3'd4, 1'b0, 5'b01000);
        tick();
        idle();
        n_checks++;
        if (bus.acc_flags !== 5'b00001) begin
            n_errors++;
            $display("FAIL acc_lag got %b want 00001", bus.acc_flags);
        end
        tick();
        n_checks++;
        if (bus.acc_flags !== 5'b01001) begin
            n_errors++;
            $display("FAIL acc_sum got %b want 01001", bus.acc_flags);
        end
        set_wr(0, 3'd5, 1'b0, 5'b11111);
        set_wr(1, 3'd7, 1'b1, 5'b10110);
        bus.clr_en   = 1'b1;
        bus.clr_addr = 3'd6;
        tick();
        idle();
        set_rd(3'd5, 5'b00000, 1'b0);
        tick();
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({bus.r_data, bus.r_valid} !== exp_v || bus.acc_flags !== 5'b01001) begin
            n_errors++;
            $display("FAIL oor_write got %b/%b acc %b want %b acc 01001", bus.r_data, bus.r_valid, bus.acc_flags, exp_v);
        end
        idle();
        set_rd(3'd0, 5'b00001, 1'b1);
        tick();
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({bus.r_data, bus.r_valid} !== exp_v) begin
            n_errors++;
            $display("FAIL oor_keep got %b/%b want %b", bus.r_data, bus.r_valid, exp_v);
        end
        idle();
        set_wr(0, 3'd2, 1'b0, 5'b10000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        n_checks++;
        if (bus.acc_flags !== 5'b00000) begin
            n_errors++;
            $display("FAIL acc_reset got %b want 00000", bus.acc_flags);
        end
        set_rd(3'd2, 5'b00000, 1'b0);
        tick();
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({bus.r_data, bus.r_valid} !== exp_v || bus.acc_flags !== 5'b00000) begin
            n_errors++;
            $display("FAIL reset_beats_write got %b/%b acc %b want %b acc 00000", bus.r_data, bus.r_valid, bus.acc_flags, exp_v);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        idle();
        tick();
        test_reset();
        test_accum();
        test_same_cycle();
        test_clear();
        test_read_first();
        test_acc_flags();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
